irq_ctrl: RTL and testbench

Interrupt controller sitting in front of the CP0 block. It collects up to N_SRC external interrupt lines, latches them as pending, applies a software mask and a fixed priority, and raises the single CP0 interrupt input one request at a time. It tracks the CP0 handshake: request, then taken, then ERET. It enforces a programmable hold-off after each ERET, and exposes the selected cause number so the handler can read it through the MFC0 path.

---
 rtl/irq_ctrl_if.sv | 32 +++
 rtl/irq_ctrl.sv | 145 ++++++++++++++
 tb/tb_irq_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Bus bundle between the interrupt controller and its CP0-side master.
// The slave modport is the controller's view; the master modport is CP0/register-decode side.
interface irq_ctrl_if #(
    parameter int unsigned N_SRC   = 8,
    parameter int unsigned CAUSE_W = 3,
    parameter int unsigned HOLD_W  = 4
) ();

    logic [N_SRC-1:0]   irq_src;
    logic               mask_we;
    logic [N_SRC-1:0]   mask_wdata;
    logic               hold_we;
    logic [HOLD_W-1:0]  hold_wdata;
    logic               ir_taken;
    logic               eret;
    logic               ir_out;
    logic [CAUSE_W-1:0] cause;
    logic               busy;
    logic [N_SRC-1:0]   pending;
    logic [N_SRC-1:0]   mask;

    modport master (
        output irq_src, mask_we, mask_wdata, hold_we, hold_wdata, ir_taken, eret,
        input  ir_out, cause, busy, pending, mask
    );

    modport slave (
        input  irq_src, mask_we, mask_wdata, hold_we, hold_wdata, ir_taken, eret,
        output ir_out, cause, busy, pending, mask
    );

endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller in front of CP0: latches source events as pending, applies the
// software mask and a fixed lowest-index-wins priority, and raises one request at a time,
// following the request -> taken -> ERET handshake with a programmable post-ERET hold-off.
// Build option: define IRQ_EDGE_EN for rising-edge sources; otherwise sources are level mode.
// Parameter constraints: 2 <= N_SRC <= 32 and 2**CAUSE_W >= N_SRC.
module irq_ctrl #(
    parameter int unsigned N_SRC   = 8,
    parameter int unsigned CAUSE_W = 3,
    parameter int unsigned HOLD_W  = 4
) (
    input  logic      i_clk,
    input  logic      i_rst,
    irq_ctrl_if.slave io_bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRaise,
        StWaitTake,
        StService,
        StHold
    } state_e;

    state_e             r_state;
    logic               r_ir_out;
    logic [CAUSE_W-1:0] r_cause;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [HOLD_W-1:0]  r_hold_len;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_mask;

    logic [N_SRC-1:0]   w_event;
    logic [N_SRC-1:0]   w_eligible;
    logic [N_SRC-1:0]   w_winner_oh;
    logic [CAUSE_W-1:0] w_winner_idx;
    logic [N_SRC-1:0]   w_clear;
    logic               w_dispatch;

`ifdef IRQ_EDGE_EN
    logic [N_SRC-1:0]   r_src_q;

    // Edge history: previous-cycle copy of the source lines.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_src_q <= '0;
        end else begin
            r_src_q <= io_bus.irq_src;
        end
    end

    assign w_event = io_bus.irq_src & ~r_src_q;
`else
    // Level mode: a high line re-arms pending every cycle it stays high.
    assign w_event = io_bus.irq_src;
`endif

    assign w_eligible = r_pending & r_mask;
    assign w_dispatch = (r_state == StIdle) && (|w_eligible);
    assign w_clear    = w_dispatch ? w_winner_oh : '0;

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        logic found;
        found        = 1'b0;
        w_winner_idx = '0;
        w_winner_oh  = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (w_eligible[i] && !found) begin
                found          = 1'b1;
                w_winner_idx   = CAUSE_W'(i);
                w_winner_oh[i] = 1'b1;
            end
        end
    end

    // Pending, mask and hold-off registers; a new event beats a same-cycle dispatch clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending  <= '0;
            r_mask     <= '0;
            r_hold_len <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_event;
            if (io_bus.mask_we) begin
                r_mask <= io_bus.mask_wdata;
            end
            if (io_bus.hold_we) begin
                r_hold_len <= io_bus.hold_wdata;
            end
        end
    end

    // Dispatch FSM with registered request pulse, cause and hold-off counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_ir_out   <= 1'b0;
            r_cause    <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_ir_out <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_dispatch) begin
                        r_cause  <= w_winner_idx;
                        r_ir_out <= 1'b1;
                        r_state  <= StRaise;
                    end
                end
                StRaise: begin
                    r_state <= StWaitTake;
                end
                StWaitTake: begin
                    // CP0 keeps the request internally, so no timeout here; eret is ignored.
                    if (io_bus.ir_taken) begin
                        r_state <= StService;
                    end
                end
                StService: begin
                    if (io_bus.eret) begin
                        r_hold_cnt <= r_hold_len;
                        r_state    <= (r_hold_len == '0) ? StIdle : StHold;
                    end
                end
                StHold: begin
                    r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    if (r_hold_cnt <= HOLD_W'(1)) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.ir_out  = r_ir_out;
    assign io_bus.cause   = r_cause;
    assign io_bus.busy    = (r_state == StRaise) || (r_state == StWaitTake) ||
                            (r_state == StService);
    assign io_bus.pending = r_pending;
    assign io_bus.mask    = r_mask;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a per-cycle vector table plus hand-written
// held-line sequences whose expectation depends on IRQ_EDGE_EN.
module tb_irq_ctrl;

    logic clk;
    logic rst;

    irq_ctrl_if #(.N_SRC(8), .CAUSE_W(3), .HOLD_W(4)) bus ();

    irq_ctrl #(
        .N_SRC   (8),
        .CAUSE_W (3),
        .HOLD_W  (4)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] src;
        logic       mwe;
        logic [7:0] mwd;
        logic       hwe;
        logic [3:0] hwd;
        logic       tk;
        logic       er;
        bit         chk;
        logic       eir;
        logic [2:0] ec;
        logic       eb;
        logic [7:0] ep;
        logic [7:0] em;
    } vec_t;

    typedef struct {
        bit         chk;
        logic       ir;
        logic [2:0] cause;
        logic       busy;
        logic [7:0] pend;
        logic [7:0] mask;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    logic [2:0] cause_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic add(input logic r, input logic [7:0] src, input logic mwe,
                       input logic [7:0] mwd, input logic hwe, input logic [3:0] hwd,
                       input logic tk, input logic er, input bit chk, input logic eir,
                       input logic [2:0] ec, input logic eb, input logic [7:0] ep,
                       input logic [7:0] em);
        vec_t v;
        v.rst = r;   v.src = src; v.mwe = mwe; v.mwd = mwd; v.hwe = hwe; v.hwd = hwd;
        v.tk  = tk;  v.er  = er;  v.chk = chk; v.eir = eir; v.ec  = ec;  v.eb  = eb;
        v.ep  = ep;  v.em  = em;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst             = v.rst;
        bus.irq_src     = v.src;
        bus.mask_we     = v.mwe;
        bus.mask_wdata  = v.mwd;
        bus.hold_we     = v.hwe;
        bus.hold_wdata  = v.hwd;
        bus.ir_taken    = v.tk;
        bus.eret        = v.er;
    endtask

    task automatic quiet();
        bus.irq_src  = '0;
        bus.mask_we  = 1'b0;
        bus.hold_we  = 1'b0;
        bus.ir_taken = 1'b0;
        bus.eret     = 1'b0;
    endtask

    initial begin
        exp_t       e;
        exp_t       p;
        int         lat;
        logic [2:0] c;

        rst            = 1'b1;
        bus.irq_src    = '0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.hold_we    = 1'b0;
        bus.hold_wdata = '0;
        bus.ir_taken   = 1'b0;
        bus.eret       = 1'b0;

        // rst  src   mwe mwd   hwe hwd tk er chk ir cs bsy pend   mask
        add(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00); // 0 reset
        add(0, 8'h00, 1, 8'hFF, 1, 3, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00); // 1 reset values
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'hFF); // 2
        add(0, 8'h04, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'hFF); // 3 pulse src2
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h04, 8'hFF); // 4 pending[2]
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1, 2, 1, 8'h00, 8'hFF); // 5 RAISE cause 2
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 0, 2, 1, 8'h00, 8'hFF); // 6 stray eret
        add(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 2, 1, 8'h00, 8'hFF); // 7 taken
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 0, 2, 1, 8'h00, 8'hFF); // 8 SERVICE, eret
        add(0, 8'h0A, 0, 8'h00, 0, 0, 0, 0, 1, 0, 2, 0, 8'h00, 8'hFF); // 9 HOLD, src 1+3
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 2, 0, 8'h0A, 8'hFF); // 10 HOLD
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 2, 0, 8'h0A, 8'hFF); // 11 HOLD
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 2, 0, 8'h0A, 8'hFF); // 12 IDLE decides
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 1, 8'h08, 8'hFF); // 13 cause 1 first
        add(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 1, 1, 8'h08, 8'hFF); // 14 taken
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 0, 1, 1, 8'h08, 8'hFF); // 15 eret (v)
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 8'h08, 8'hFF); // 16 HOLD
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 8'h08, 8'hFF); // 17 HOLD
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 8'h08, 8'hFF); // 18 HOLD
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 8'h08, 8'hFF); // 19 IDLE
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1, 3, 1, 8'h00, 8'hFF); // 20 v+5 cause 3
        add(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 3, 1, 8'h00, 8'hFF); // 21 taken
        add(0, 8'h00, 1, 8'h00, 1, 0, 0, 0, 1, 0, 3, 1, 8'h00, 8'hFF); // 22 mask off in svc
        add(0, 8'h20, 0, 8'h00, 0, 0, 0, 0, 1, 0, 3, 1, 8'h00, 8'h00); // 23 still SERVICE
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 0, 3, 1, 8'h20, 8'h00); // 24 eret, hold 0
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 3, 0, 8'h20, 8'h00); // 25 masked, idle
        add(0, 8'h00, 1, 8'h20, 0, 0, 0, 0, 1, 0, 3, 0, 8'h20, 8'h00); // 26 unmask src5
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 3, 0, 8'h20, 8'h20); // 27 IDLE decides
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1, 5, 1, 8'h00, 8'h20); // 28 write+2
        add(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 5, 1, 8'h00, 8'h20); // 29 taken
        add(0, 8'h00, 1, 8'hFF, 0, 0, 0, 1, 1, 0, 5, 1, 8'h00, 8'h20); // 30 eret, mask FF
        add(0, 8'h01, 0, 8'h00, 0, 0, 0, 0, 1, 0, 5, 0, 8'h00, 8'hFF); // 31 pulse src0
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 5, 0, 8'h01, 8'hFF); // 32
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 1, 8'h00, 8'hFF); // 33 cause 0
        add(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 1, 8'h00, 8'hFF); // 34 taken
        add(0, 8'h01, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1, 8'h00, 8'hFF); // 35 src0 in svc
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 1, 8'h01, 8'hFF); // 36 eret, hold 0
        add(0, 8'h01, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h01, 8'hFF); // 37 set vs clear
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 1, 8'h01, 8'hFF); // 38 set wins
        add(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 1, 8'h01, 8'hFF); // 39 taken
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 1, 8'h01, 8'hFF); // 40 eret
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h01, 8'hFF); // 41 IDLE
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 1, 8'h00, 8'hFF); // 42 third cause 0
        add(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1, 8'h00, 8'hFF); // 43 rst in WAIT
        add(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00); // 44 stray taken
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0, 8'h00, 8'h00); // 45 stray eret
        add(0, 8'h02, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00); // 46 src1 masked
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h02, 8'h00); // 47
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h02, 8'h00); // 48

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            p.chk   = vecs[i].chk;
            p.ir    = vecs[i].eir;
            p.cause = vecs[i].ec;
            p.busy  = vecs[i].eb;
            p.pend  = vecs[i].ep;
            p.mask  = vecs[i].em;
            sb.push_back(p);
            e = sb.pop_front();
            if (e.chk) begin
                cmp("ir_out",  i, 32'(bus.ir_out),  32'(e.ir));
                cmp("cause",   i, 32'(bus.cause),   32'(e.cause));
                cmp("busy",    i, 32'(bus.busy),    32'(e.busy));
                cmp("pending", i, 32'(bus.pending), 32'(e.pend));
                cmp("mask",    i, 32'(bus.mask),    32'(e.mask));
            end
        end

        // Held line on source 3 with hold-off 2; pending[1] stays set but masked.
        @(posedge clk);
        #1;
        quiet();
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 8'h08;
        bus.hold_we    = 1'b1;
        bus.hold_wdata = 4'd2;
        bus.irq_src    = 8'h08;
        cause_q.push_back(3'd3);
        @(posedge clk);
        #1;
        bus.mask_we = 1'b0;
        bus.hold_we = 1'b0;
        lat = 1;
        while (!bus.ir_out && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        cmp("held_first_latency", 49, 32'(lat), 32'd2);
        c = cause_q.pop_front();
        cmp("held_first_cause", 49, 32'(bus.cause), 32'(c));

        @(posedge clk);
        #1;
        bus.ir_taken = 1'b1;
        cmp("held_wait_busy", 50, 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        bus.ir_taken = 1'b0;
        bus.eret     = 1'b1;
        @(posedge clk);
        #1;
        bus.eret = 1'b0;
        lat = 1;
        while (!bus.ir_out && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
`ifdef IRQ_EDGE_EN
        // A line that simply stays high must not produce a second request.
        cmp("edge_no_retrigger_lat", 51, 32'(lat), 32'd12);
        cmp("edge_no_retrigger_ir", 51, 32'(bus.ir_out), 32'd0);
        cmp("edge_pending_after", 51, 32'(bus.pending), 32'h02);
`else
        // Level line still high through eret: re-request at eret + hold + 2.
        cause_q.push_back(3'd3);
        cmp("level_retrigger_lat", 51, 32'(lat), 32'd4);
        c = cause_q.pop_front();
        cmp("level_retrigger_cause", 51, 32'(bus.cause), 32'(c));
        cmp("level_pending_after", 51, 32'(bus.pending), 32'h0A);
`endif

        quiet();
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
